ras_stack: RTL and testbench
============================

RAS_STACK -- requirements
Module: ras_stack

Interface
- REQ-001: Parameter RAS_DEPTH, default 8, number of stack entries; SHALL be a power of 2 ≥ 2.
- REQ-002: Parameter LOG_RAS_DEPTH, default $clog2(RAS_DEPTH), pointer width.
- REQ-003: Parameter RAS_TARGET_WIDTH, default 12 (equal to BTB_TARGET_WIDTH), stored return-target width.
- REQ-004: CLK  in  1  sole clock; all state SHALL update on its rising edge.
- REQ-005: RST  in  1  reset, synchronous, active-high.
- REQ-006: push_valid  in  1  call predicted this cycle.
- REQ-007: push_target  in  RAS_TARGET_WIDTH  return target to push.
- REQ-008: pop_valid  in  1  return predicted this cycle.
- REQ-009: restore_valid  in  1  mispredict/flush restore request.
- REQ-010: restore_index  in  LOG_RAS_DEPTH  checkpointed pointer.
- REQ-011: restore_count  in  LOG_RAS_DEPTH+1  checkpointed occupancy.
- REQ-012: top_valid  out  1  stack non-empty (count > 0).
- REQ-013: top_target  out  RAS_TARGET_WIDTH  entry at index (ptr−1) mod RAS_DEPTH.
- REQ-014: ras_index  out  LOG_RAS_DEPTH  current ptr, for checkpointing with branch.
- REQ-015: ras_count  out  LOG_RAS_DEPTH+1  current occupancy, for checkpointing.

Function
- REQ-016: State SHALL be a circular array of RAS_DEPTH entries, ptr (next free slot) and count (0..RAS_DEPTH).
- REQ-017: top_valid, top_target, ras_index and ras_count SHALL be combinational from current registered state only (no input-to-output path); a pop SHALL consume the top_target visible in the same cycle.
- REQ-018: Push only: entry[ptr] ← push_target; ptr ← ptr+1 mod RAS_DEPTH; count ← min(count+1, RAS_DEPTH).
- REQ-019: Push when count == RAS_DEPTH SHALL overwrite the oldest entry (wrap-around); count stays RAS_DEPTH.
- REQ-020: Pop only, count > 0: ptr ← ptr−1 mod RAS_DEPTH; count ← count−1; entry contents unchanged.
- REQ-021: Pop only, count == 0: no state change; top_valid stays 0.
- REQ-022: Push and pop in same cycle (call-return): entry[(ptr−1) mod RAS_DEPTH] ← push_target; ptr unchanged; if count == 0, write entry[ptr], ptr ← ptr+1 and count ← 1.
- REQ-023: Restore: ptr ← restore_index; count ← restore_count; entries unchanged; restore_count > RAS_DEPTH SHALL be clamped to RAS_DEPTH.
- REQ-024: restore_valid SHALL take priority over push_valid/pop_valid in the same cycle; push/pop SHALL be ignored.
- REQ-025: Restored stack SHALL deliver entries written before the checkpoint unless overwritten by later pushes (best-effort prediction, no correctness guarantee).
- REQ-026: Arithmetic on ptr SHALL be modulo RAS_DEPTH; count SHALL never underflow below 0 or exceed RAS_DEPTH.

Reset
- REQ-027: With RST high at a rising edge: ptr ← 0, count ← 0, all entries ← 0; push/pop/restore ignored that cycle.
- REQ-028: After reset: top_valid = 0, top_target = 0, ras_index = 0, ras_count = 0.
- REQ-029: RST asserted mid-sequence SHALL discard all stack contents regardless of other inputs.

Verification
- REQ-030: Reset, push 0x111, 0x222, 0x333 → top_target 0x333, ras_index 3, ras_count 3; pop, pop → top_target 0x111, count 1.
- REQ-031: Push 9 targets 0x001..0x009 from reset → count 8, ras_index 1, top 0x009; 8 pops yield 0x009..0x002; 9th pop → top_valid 0, no change.
- REQ-032: Pop on empty stack → ptr 0, count 0, top_valid 0; subsequent push 0x0AB → top 0x0AB, count 1.
- REQ-033: Stack {0x100,0x200}, push+pop with 0x300 → top 0x300, count 2, ras_index 2; from empty, push+pop 0x055 → count 1, top 0x055.
- REQ-034: Checkpoint (index 2, count 2) after pushing 0x100,0x200; pop twice, push 0x7FF; restore_valid with push_valid same cycle → ras_index 2, count 2, top 0x200 (overwritten slot 0 irrelevant), push ignored.
- REQ-035: RST asserted while count 5 and push_valid high → next cycle count 0, ras_index 0, top_valid 0.

Source files
------------

// File: rtl/ras_stack.sv
// Return address stack: circular buffer of predicted return targets with
// overwrite-on-overflow, call-return replacement and checkpoint restore.
module ras_stack #(
  parameter int RAS_DEPTH        = 8,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
  parameter int RAS_TARGET_WIDTH = 12
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    restore_index,
  input  logic [LOG_RAS_DEPTH:0]      restore_count,
  output logic                        top_valid,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic [LOG_RAS_DEPTH-1:0]    ras_index,
  output logic [LOG_RAS_DEPTH:0]      ras_count
);

  localparam logic [LOG_RAS_DEPTH:0]   FULL = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);
  localparam logic [LOG_RAS_DEPTH-1:0] ONE  = LOG_RAS_DEPTH'(1);

  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    ptr, ptr_prev, ptr_next;
  logic [LOG_RAS_DEPTH:0]      count, count_next;
  logic                        wr_en;
  logic [LOG_RAS_DEPTH-1:0]    wr_idx;

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign ptr_prev = ptr - ONE;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    ptr_next   = ptr;
    count_next = count;
    wr_en      = 1'b0;
    wr_idx     = ptr;
    if (restore_valid) begin
      ptr_next   = restore_index;
      count_next = (restore_count > FULL) ? FULL : restore_count;
    end else if (push_valid && pop_valid) begin
      wr_en = 1'b1;
      if (count == '0) begin
        ptr_next   = ptr + ONE;
        count_next = (LOG_RAS_DEPTH+1)'(1);
      end else begin
        wr_idx = ptr_prev;
      end
    end else if (push_valid) begin
      wr_en      = 1'b1;
      ptr_next   = ptr + ONE;
      count_next = (count == FULL) ? FULL : count + 1'b1;
    end else if (pop_valid && count != '0) begin
      ptr_next   = ptr_prev;
      count_next = count - 1'b1;
    end
  end

  // NOTE: the target array is cleared on reset because reset must discard all
  // stack contents and leave top_target at zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only.
      ptr   <= ptr_next;
      count <= count_next;
      if (wr_en) entries[wr_idx] <= push_target;
    end
  end

  assign top_valid  = (count != '0);
  assign top_target = entries[ptr_prev];
  assign ras_index  = ptr;
  assign ras_count  = count;

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: directed scenarios plus random traffic
// compared against an array/integer model of the stack.
module tb_ras_stack;

  localparam int D = 8;
  localparam int L = 3;
  localparam int W = 12;

  logic         CLK = 1'b0;
  logic         RST;
  logic         push_valid, pop_valid, restore_valid;
  logic [W-1:0] push_target;
  logic [L-1:0] restore_index;
  logic [L:0]   restore_count;
  logic         top_valid;
  logic [W-1:0] top_target;
  logic [L-1:0] ras_index;
  logic [L:0]   ras_count;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers and an array.
  logic [W-1:0] m_mem [D];
  int           m_ptr, m_cnt;

  ras_stack #(.RAS_DEPTH(D), .LOG_RAS_DEPTH(L), .RAS_TARGET_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid),
    .restore_valid(restore_valid), .restore_index(restore_index),
    .restore_count(restore_count),
    .top_valid(top_valid), .top_target(top_target),
    .ras_index(ras_index), .ras_count(ras_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_step(input bit rst, input bit push, input logic [W-1:0] tgt,
                                     input bit pop, input bit rest, input int ri, input int rc);
    if (rst) begin
      m_ptr = 0;
      m_cnt = 0;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else if (rest) begin
      m_ptr = ri;
      m_cnt = (rc > D) ? D : rc;
    end else if (push && pop) begin
      if (m_cnt == 0) begin
        m_mem[m_ptr] = tgt;
        m_ptr = (m_ptr + 1) % D;
        m_cnt = 1;
      end else begin
        m_mem[(m_ptr + D - 1) % D] = tgt;
      end
    end else if (push) begin
      m_mem[m_ptr] = tgt;
      m_ptr = (m_ptr + 1) % D;
      m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
    end else if (pop && m_cnt > 0) begin
      m_ptr = (m_ptr + D - 1) % D;
      m_cnt = m_cnt - 1;
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, "_valid"}, 32'(top_valid), 32'(m_cnt > 0));
    check({tag, "_index"}, 32'(ras_index), 32'(m_ptr));
    check({tag, "_count"}, 32'(ras_count), 32'(m_cnt));
    check({tag, "_top"},   32'(top_target), 32'(m_mem[(m_ptr + D - 1) % D]));
  endtask

  // One clock: apply inputs, advance the model, then compare #1 after the edge.
  task automatic cycle(input string tag, input bit rst, input bit push, input logic [W-1:0] tgt,
                       input bit pop, input bit rest, input int ri, input int rc);
    RST           = rst;
    push_valid    = push;
    push_target   = tgt;
    pop_valid     = pop;
    restore_valid = rest;
    restore_index = L'(ri);
    restore_count = (L+1)'(rc);
    @(posedge CLK);
    model_step(rst, push, tgt, pop, rest, ri, rc);
    #1;
    RST = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
    compare_model(tag);
  endtask

  task automatic do_reset();
    cycle("rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic push(input logic [W-1:0] t);
    cycle("push", 1'b0, 1'b1, t, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pop();
    cycle("pop", 1'b0, 1'b0, '0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    RST = 1'b1; push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
    push_target = '0; restore_index = '0; restore_count = '0;
    m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < D; i++) m_mem[i] = 12'hFFF;

    // Reset state, with a push held high to show it is ignored.
    cycle("rst_push", 1'b1, 1'b1, 12'hABC, 1'b0, 1'b0, 0, 0);
    check("reset_valid", 32'(top_valid), 0);
    check("reset_top",   32'(top_target), 0);
    check("reset_index", 32'(ras_index), 0);
    check("reset_count", 32'(ras_count), 0);

    // Basic LIFO order.
    push(12'h111); push(12'h222); push(12'h333);
    check("lifo_top",   32'(top_target), 32'h333);
    check("lifo_index", 32'(ras_index), 3);
    check("lifo_count", 32'(ras_count), 3);
    pop(); pop();
    check("lifo_pop_top",   32'(top_target), 32'h111);
    check("lifo_pop_count", 32'(ras_count), 1);

    // Overflow wraps and overwrites the oldest entry.
    do_reset();
    for (int i = 1; i <= 9; i++) push(W'(i));
    check("ovf_count", 32'(ras_count), 8);
    check("ovf_index", 32'(ras_index), 1);
    check("ovf_top",   32'(top_target), 32'h009);
    for (int k = 0; k < 8; k++) begin
      check("ovf_pop_seq", 32'(top_target), 32'(9 - k));
      pop();
    end
    check("ovf_empty_valid", 32'(top_valid), 0);
    pop();
    check("ovf_extra_count", 32'(ras_count), 0);
    check("ovf_extra_index", 32'(ras_index), 1);

    // Pop on empty, then push.
    do_reset();
    pop();
    check("empty_pop_index", 32'(ras_index), 0);
    check("empty_pop_count", 32'(ras_count), 0);
    push(12'h0AB);
    check("empty_push_top",   32'(top_target), 32'h0AB);
    check("empty_push_count", 32'(ras_count), 1);

    // Simultaneous push and pop.
    do_reset();
    push(12'h100); push(12'h200);
    cycle("pp", 1'b0, 1'b1, 12'h300, 1'b1, 1'b0, 0, 0);
    check("pp_top",   32'(top_target), 32'h300);
    check("pp_count", 32'(ras_count), 2);
    check("pp_index", 32'(ras_index), 2);
    do_reset();
    cycle("pp0", 1'b0, 1'b1, 12'h055, 1'b1, 1'b0, 0, 0);
    check("pp_empty_count", 32'(ras_count), 1);
    check("pp_empty_top",   32'(top_target), 32'h055);

    // Checkpoint restore beats a same-cycle push.
    do_reset();
    push(12'h100); push(12'h200);
    pop(); pop(); push(12'h7FF);
    cycle("rest", 1'b0, 1'b1, 12'h5A5, 1'b0, 1'b1, 2, 2);
    check("restore_index", 32'(ras_index), 2);
    check("restore_count", 32'(ras_count), 2);
    check("restore_top",   32'(top_target), 32'h200);
    cycle("rest_clamp", 1'b0, 1'b0, '0, 1'b1, 1'b1, 5, 15);
    check("restore_clamp", 32'(ras_count), 8);

    // Reset mid-sequence with a push pending.
    do_reset();
    for (int i = 0; i < 5; i++) push(W'(12'h010 + i));
    cycle("rst_mid", 1'b1, 1'b1, 12'h777, 1'b0, 1'b0, 0, 0);
    check("rst_mid_count", 32'(ras_count), 0);
    check("rst_mid_index", 32'(ras_index), 0);
    check("rst_mid_valid", 32'(top_valid), 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int  sel;
      bit  r, p, q, s;
      sel = int'($urandom_range(0, 99));
      r = (sel < 2);
      s = (sel >= 2 && sel < 8);
      p = ($urandom_range(0, 99) < 50);
      q = ($urandom_range(0, 99) < 45);
      cycle("rand", r, p, W'($urandom), q, s,
            int'($urandom_range(0, D - 1)), int'($urandom_range(0, 2 * D - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
